saber_centroid_tracker: RTL and testbench

- Upstream stage of the saber trace renderer.
- Accumulates coordinates of every masked (saber-coloured) camera pixel over one frame.
- At each frame boundary, computes the integer centroid with a shared sequential divider and presents it as the tip position.
- The trace renderer samples the position on its next nf pulse.

---
 rtl/saber_centroid_tracker.sv | 229 ++++++++++++++++++++++
 tb/tb_saber_centroid_tracker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/saber_centroid_tracker.sv
// Saber tip tracker: masked-pixel centroid per frame, sequential divide.
// Optional SMOOTHING_EN: exponential smoothing of the reported tip.
module saber_centroid_tracker #(
  parameter int unsigned MIN_PIXELS  = 16,
  parameter int unsigned H_WIDTH     = 11,
  parameter int unsigned V_WIDTH     = 10,
  parameter int unsigned ALPHA_SHIFT = 2
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [H_WIDTH-1:0] hcount_in,
  input  logic [V_WIDTH-1:0] vcount_in,
  input  logic               valid_in,
  input  logic               mask_in,
  input  logic               nf_in,
  output logic [H_WIDTH:0]   x_out,
  output logic [V_WIDTH:0]   y_out,
  output logic               detected_out,
  output logic               pos_valid_out,
  output logic               busy_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_DIVX  = 3'd2;
  localparam logic [2:0] S_DIVY  = 3'd3;
  localparam logic [2:0] S_UPD   = 3'd4;

  localparam logic [20:0] MIN_C = 21'(MIN_PIXELS);

  logic [31:0] sum_x_q, sum_x_d;
  logic [31:0] sum_y_q, sum_y_d;
  logic [20:0] cnt_q, cnt_d;
  logic [31:0] snap_x_q, snap_x_d;
  logic [31:0] snap_y_q, snap_y_d;
  logic [20:0] snap_c_q, snap_c_d;
  logic [2:0]  state_q, state_d;
  logic [4:0]  step_q, step_d;
  logic [31:0] quo_q, quo_d;
  logic [20:0] rem_q, rem_d;
  logic        det_q, det_d;
  logic [H_WIDTH-1:0] cx_q, cx_d;
  logic [V_WIDTH-1:0] cy_q, cy_d;
  logic [H_WIDTH-1:0] x_q, x_d;
  logic [V_WIDTH-1:0] y_q, y_d;
  logic        detected_q, detected_d;
  logic        pv_q, pv_d;
  logic        busy_q, busy_d;

  logic        pix;
  logic [20:0] cnt_inc;
  logic [31:0] acc_x, acc_y;
  logic [20:0] acc_c;
  logic [21:0] rem_sh;
  logic [21:0] div_ext;
  logic        ge;
  logic [20:0] rem_nx;
  logic [31:0] quo_nx;
  logic [H_WIDTH-1:0] clip_x;
  logic [V_WIDTH-1:0] clip_y;
  logic [H_WIDTH-1:0] x_new;
  logic [V_WIDTH-1:0] y_new;

  assign pix     = valid_in & mask_in;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 21'd1;
  assign acc_x   = pix ? sum_x_q + 32'(hcount_in) : sum_x_q;
  assign acc_y   = pix ? sum_y_q + 32'(vcount_in) : sum_y_q;
  assign acc_c   = pix ? cnt_inc : cnt_q;

  // One restoring-division step; the dividend shifts out of quo_q.
  assign rem_sh  = {rem_q, quo_q[31]};
  assign div_ext = {1'b0, snap_c_q};
  assign ge      = rem_sh >= div_ext;
  assign rem_nx  = ge ? 21'(rem_sh - div_ext) : rem_sh[20:0];
  assign quo_nx  = {quo_q[30:0], ge};

  assign clip_x = (|quo_nx[31:H_WIDTH]) ? '1 : quo_nx[H_WIDTH-1:0];
  assign clip_y = (|quo_nx[31:V_WIDTH]) ? '1 : quo_nx[V_WIDTH-1:0];

`ifdef SMOOTHING_EN
  localparam int unsigned XW = H_WIDTH + 2;
  localparam int unsigned YW = V_WIDTH + 2;
  logic signed [XW-1:0] dx, x_sm;
  logic signed [YW-1:0] dy, y_sm;
  assign dx   = $signed({2'b00, cx_q}) - $signed({2'b00, x_q});
  assign x_sm = $signed({2'b00, x_q}) + (dx >>> ALPHA_SHIFT);
  assign dy   = $signed({2'b00, cy_q}) - $signed({2'b00, y_q});
  assign y_sm = $signed({2'b00, y_q}) + (dy >>> ALPHA_SHIFT);
  // After reset or a lost frame there is no history: load directly.
  assign x_new = detected_q ? H_WIDTH'(x_sm) : cx_q;
  assign y_new = detected_q ? V_WIDTH'(y_sm) : cy_q;
`else
  assign x_new = cx_q;
  assign y_new = cy_q;
`endif

  // Accumulation, frame snapshot and divider FSM next-state.
  always_comb begin
    sum_x_d    = acc_x;
    sum_y_d    = acc_y;
    cnt_d      = acc_c;
    snap_x_d   = snap_x_q;
    snap_y_d   = snap_y_q;
    snap_c_d   = snap_c_q;
    state_d    = state_q;
    step_d     = step_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    det_d      = det_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    x_d        = x_q;
    y_d        = y_q;
    detected_d = detected_q;
    pv_d       = 1'b0;

    if (nf_in) begin
      snap_x_d = acc_x;
      snap_y_d = acc_y;
      snap_c_d = acc_c;
      sum_x_d  = pix ? 32'(hcount_in) : '0;
      sum_y_d  = pix ? 32'(vcount_in) : '0;
      cnt_d    = pix ? 21'd1 : '0;
    end

    unique case (state_q)
      S_IDLE: begin
      end
      S_LATCH: begin
        if (snap_c_q < MIN_C) begin
          det_d   = 1'b0;
          state_d = S_UPD;
        end else begin
          det_d   = 1'b1;
          quo_d   = snap_x_q;
          rem_d   = '0;
          step_d  = '0;
          state_d = S_DIVX;
        end
      end
      S_DIVX: begin
        quo_d  = quo_nx;
        rem_d  = rem_nx;
        step_d = step_q + 5'd1;
        if (&step_q) begin
          cx_d    = clip_x;
          quo_d   = snap_y_q;
          rem_d   = '0;
          state_d = S_DIVY;
        end
      end
      S_DIVY: begin
        quo_d  = quo_nx;
        rem_d  = rem_nx;
        step_d = step_q + 5'd1;
        if (&step_q) begin
          cy_d    = clip_y;
          state_d = S_UPD;
        end
      end
      S_UPD: begin
        pv_d       = 1'b1;
        detected_d = det_q;
        if (det_q) begin
          x_d = x_new;
          y_d = y_new;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new frame always wins: any in-flight division is dropped.
    if (nf_in) state_d = S_LATCH;
  end

  // Busy stays up through the cycle that carries the result pulse.
  assign busy_d = (state_d != S_IDLE) | pv_d;

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sum_x_q    <= '0;
      sum_y_q    <= '0;
      cnt_q      <= '0;
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      snap_c_q   <= '0;
      state_q    <= S_IDLE;
      step_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      det_q      <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      detected_q <= 1'b0;
      pv_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sum_x_q    <= sum_x_d;
      sum_y_q    <= sum_y_d;
      cnt_q      <= cnt_d;
      snap_x_q   <= snap_x_d;
      snap_y_q   <= snap_y_d;
      snap_c_q   <= snap_c_d;
      state_q    <= state_d;
      step_q     <= step_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      det_q      <= det_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      x_q        <= x_d;
      y_q        <= y_d;
      detected_q <= detected_d;
      pv_q       <= pv_d;
      busy_q     <= busy_d;
    end
  end

  assign x_out         = {1'b0, x_q};
  assign y_out         = {1'b0, y_q};
  assign detected_out  = detected_q;
  assign pos_valid_out = pv_q;
  assign busy_out      = busy_q;

endmodule

// File: tb/tb_saber_centroid_tracker.sv
// Bench for saber_centroid_tracker: frame-level model, two thresholds.
// Directed frames with literal centroids pin the model.
module tb_saber_centroid_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid, mask, nf;
  logic [10:0] hc;
  logic [9:0]  vc;

  logic [11:0] x0, x1;
  logic [10:0] y0, y1;
  logic        det0, det1, pv0, pv1, busy0, busy1;

  saber_centroid_tracker #(.MIN_PIXELS(16)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n),
    .hcount_in(hc), .vcount_in(vc),
    .valid_in(valid), .mask_in(mask), .nf_in(nf),
    .x_out(x0), .y_out(y0), .detected_out(det0),
    .pos_valid_out(pv0), .busy_out(busy0)
  );

  saber_centroid_tracker #(.MIN_PIXELS(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n),
    .hcount_in(hc), .vcount_in(vc),
    .valid_in(valid), .mask_in(mask), .nf_in(nf),
    .x_out(x1), .y_out(y1), .detected_out(det1),
    .pos_valid_out(pv1), .busy_out(busy1)
  );

  int total = 0;
  int bad   = 0;

  function automatic void check(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endfunction

  // Frame-level model: sums per frame, result due N cycles after nf.
  int     minp [2] = '{16, 1};
  longint ax [2], ay [2], ac [2];
  int     mx [2], my [2];
  bit     mdet [2], mpv [2], mbusy [2];
  bit     pend [2], pdet [2];
  int     pcnt [2], px [2], py [2];
  bit     live = 1'b0;

  function automatic void model_step(int i);
    longint sx, sy, c;
    bit p;
    if (!rst_n) begin
      ax[i] = 0; ay[i] = 0; ac[i] = 0;
      mx[i] = 0; my[i] = 0;
      mdet[i] = 0; mpv[i] = 0; mbusy[i] = 0;
      pend[i] = 0;
      return;
    end
    mpv[i] = 0;
    if (pend[i]) begin
      pcnt[i]--;
      if (pcnt[i] == 0) begin
        pend[i] = 0;
        mpv[i]  = 1;
        if (pdet[i]) begin
`ifdef SMOOTHING_EN
          if (mdet[i]) begin
            mx[i] = mx[i] + ((px[i] - mx[i]) >>> 2);
            my[i] = my[i] + ((py[i] - my[i]) >>> 2);
          end else begin
            mx[i] = px[i];
            my[i] = py[i];
          end
`else
          mx[i] = px[i];
          my[i] = py[i];
`endif
        end
        mdet[i] = pdet[i];
      end
    end
    p = valid && mask;
    sx = ax[i] + (p ? longint'(hc) : 0);
    sy = ay[i] + (p ? longint'(vc) : 0);
    c  = ac[i] + (p ? 1 : 0);
    if (c > 2097151) c = 2097151;
    if (nf) begin
      ax[i] = p ? longint'(hc) : 0;
      ay[i] = p ? longint'(vc) : 0;
      ac[i] = p ? 1 : 0;
      pend[i] = 1;
      if (c >= minp[i]) begin
        pdet[i] = 1;
        px[i] = int'((sx / c > 2047) ? 2047 : sx / c);
        py[i] = int'((sy / c > 1023) ? 1023 : sy / c);
        pcnt[i] = 66;
      end else begin
        pdet[i] = 0;
        pcnt[i] = 2;
      end
    end else begin
      ax[i] = sx; ay[i] = sy; ac[i] = c;
    end
    mbusy[i] = pend[i] || mpv[i];
  endfunction

  // Every-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    if (!rst_n) live = 1'b1;
    #1;
    if (live) begin
      check("x0", x0, mx[0]);
      check("y0", y0, my[0]);
      check("det0", det0, mdet[0]);
      check("pv0", pv0, mpv[0]);
      check("busy0", busy0, mbusy[0]);
      check("x1", x1, mx[1]);
      check("y1", y1, my[1]);
      check("det1", det1, mdet[1]);
      check("pv1", pv1, mpv[1]);
      check("busy1", busy1, mbusy[1]);
    end
  end

  task automatic tick(input bit v, input bit m,
                      input int h, input int vv, input bit n);
    @(negedge clk);
    valid = v;
    mask  = m;
    hc    = h[10:0];
    vc    = vv[9:0];
    nf    = n;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic pixels(input int n, input int h, input int vv);
    for (int k = 0; k < n; k++) tick(1, 1, h, vv, 0);
  endtask

  // Count edges after the nf edge until the chosen pulse appears.
  task automatic wait_pv(input int i, input int exp, input string nm);
    int k;
    @(negedge clk);
    valid = 0; mask = 0; nf = 0;
    for (k = 1; k <= 100; k++) begin
      @(posedge clk);
      #2;
      if ((i == 0) ? pv0 : pv1) break;
    end
    check(nm, k, exp);
  endtask

  initial begin
    rst_n = 0; valid = 0; mask = 0; nf = 0; hc = '0; vc = '0;
    idle(3);
    check("rst x0", x0, 0);
    check("rst det0", det0, 0);
    check("rst busy0", busy0, 0);
    @(negedge clk) rst_n = 1;
    idle(2);

    // Single pixel; only the MIN_PIXELS=1 instance detects.
    tick(1, 0, 7, 7, 0);
    tick(1, 1, 100, 50, 0);
    tick(1, 0, 300, 60, 0);
    tick(0, 0, 0, 0, 1);
    wait_pv(1, 66, "lat single");
    check("single x1", x1, 100);
    check("single y1", y1, 50);
    check("single det1", det1, 1);
    check("single det0", det0, 0);
    check("model px1", mx[1], 100);
    idle(3);

    // 10x10 square: 204.5 / 304.5 truncate.
    for (int v = 300; v < 310; v++)
      for (int h = 200; h < 210; h++) tick(1, 1, h, v, 0);
    tick(0, 0, 0, 0, 1);
    wait_pv(0, 66, "lat square");
    check("square x0", x0, 204);
    check("square y0", y0, 304);
    check("square det0", det0, 1);
    check("model px0", mx[0], 204);
    idle(3);

    // Five pixels: below 16, held outputs; instance 1 detects 14/21.
    tick(1, 1, 10, 20, 0);
    tick(1, 1, 12, 20, 0);
    tick(1, 1, 14, 22, 0);
    tick(1, 1, 16, 22, 0);
    tick(1, 1, 18, 24, 0);
    tick(0, 0, 0, 0, 1);
    wait_pv(0, 2, "lat five");
    check("five det0", det0, 0);
    check("five x0", x0, 204);
    check("five y0", y0, 304);
    idle(70);
    check("five x1", x1, 14);
    check("five y1", y1, 21);

    // Empty frame: both below threshold.
    tick(0, 0, 0, 0, 1);
    wait_pv(0, 2, "lat empty");
    check("empty x0", x0, 204);
    check("empty det1", det1, 0);
    check("empty x1", x1, 14);
    idle(3);

    // Threshold edge: 15 pixels rejected, 16 accepted.
    pixels(15, 40, 30);
    tick(0, 0, 0, 0, 1);
    wait_pv(0, 2, "lat fifteen");
    check("fifteen det0", det0, 0);
    pixels(16, 40, 30);
    tick(0, 0, 0, 0, 1);
    wait_pv(0, 66, "lat sixteen");
    check("sixteen x0", x0, 40);
    check("sixteen y0", y0, 30);
    check("sixteen det0", det0, 1);
    idle(3);

    // Second nf 20 cycles into the divide abandons the first frame.
    pixels(20, 600, 500);
    tick(0, 0, 0, 0, 1);
    pixels(21, 500, 400);
    tick(0, 0, 0, 0, 1);
    wait_pv(0, 66, "lat abort");
    check("abort x0", x0, 500);
    check("abort y0", y0, 400);
    idle(3);

    // Reset pulse during the y divide, then a corner frame.
    pixels(16, 800, 600);
    tick(0, 0, 0, 0, 1);
    idle(40);
    @(negedge clk) rst_n = 0;
    @(negedge clk) rst_n = 1;
    check("rstdiv x0", x0, 0);
    check("rstdiv y0", y0, 0);
    check("rstdiv busy0", busy0, 0);
    check("rstdiv pv0", pv0, 0);
    pixels(16, 1279, 719);
    tick(0, 0, 0, 0, 1);
    wait_pv(0, 66, "lat corner");
    check("corner x0", x0, 1279);
    check("corner y0", y0, 719);
    idle(3);

    // nf pixel counted twice; next nf lands on the UPDATE cycle.
    pixels(15, 33, 44);
    tick(1, 1, 33, 44, 1);
    for (int k = 0; k < 65; k++) begin
      if (k < 20) tick(1, 1, 2, 3, 0);
      else tick(0, 0, 0, 0, 0);
    end
    tick(0, 0, 0, 0, 1);
    @(posedge clk);
    #2;
    check("coin pv0", pv0, 1);
    check("coin x0", x0, 33);
    check("coin busy0", busy0, 1);
    wait_pv(0, 66, "lat coin");
    check("coin2 x0", x0, 3);
    check("coin2 y0", y0, 4);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
